// File: rtl/uart_cmd_rx_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_cmd_rx_if
// Output bundle of the UART command receiver: received bytes, error strobes and
// the decoded control strobes and levels for the capture and SCCB paths.
//   byte_data  [7:0] last correctly framed byte
//   byte_valid       1-cycle pulse when byte_data updates
//   frame_err        1-cycle pulse when a stop bit is sampled low
//   take_pic         1-cycle pulse, capture command
//   hdr_en           level, HDR enable
//   conf_addr  [7:0] SCCB register address
//   conf_data  [7:0] SCCB register data
//   sccb_start       1-cycle pulse, conf_addr/conf_data valid
//   cmd_err          1-cycle pulse on packet rejection
//   busy_led         high while a packet is being assembled
// master: the receiver driving the bundle.  slave: any consumer.
// -----------------------------------------------------------------------------
interface uart_cmd_rx_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       take_pic;
  logic       hdr_en;
  logic [7:0] conf_addr;
  logic [7:0] conf_data;
  logic       sccb_start;
  logic       cmd_err;
  logic       busy_led;

  modport master (
    output byte_data, byte_valid, frame_err, take_pic, hdr_en,
           conf_addr, conf_data, sccb_start, cmd_err, busy_led
  );

  modport slave (
    input  byte_data, byte_valid, frame_err, take_pic, hdr_en,
           conf_addr, conf_data, sccb_start, cmd_err, busy_led
  );
endinterface

// File: rtl/uart_cmd_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_cmd_rx
// 8N1 UART receiver plus 5-byte command packet decoder
// (0xA5, CMD, ADDR, DATA, CHK with CHK = CMD ^ ADDR ^ DATA).
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   RX      serial input, idle high, asynchronous to clk
//   cmd_if  uart_cmd_rx_if.master, received bytes and decoded commands
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit
//   TIMEOUT_CLKS  idle cycles allowed between packet bytes before resync
// -----------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 1154,
  parameter int TIMEOUT_CLKS = 23080
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RX,
  uart_cmd_rx_if.master  cmd_if
);

  localparam int CNT_MAX  = (CLKS_PER_BIT > TIMEOUT_CLKS) ? CLKS_PER_BIT : TIMEOUT_CLKS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_CMD, P_ADDR, P_DATA, P_CHK} parse_state_t;

  // ---------------- RX synchroniser ----------------
  logic rx_meta_reg;
  logic rx_s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // ---------------- Receiver FSM ----------------
  rx_state_t        rx_state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       byte_data_reg;
  logic             byte_valid_reg;
  logic             frame_err_reg;

  logic baud_done;
  logic half_done;
  logic frame_evt;

  assign baud_done = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign half_done = (baud_cnt_reg == CNT_W'(HALF_BIT - 1));
  // Bad stop bit seen this cycle; lets the parser raise cmd_err on the same
  // edge that raises frame_err, so both pulses line up.
  assign frame_evt = (rx_state_reg == R_STOP) && baud_done && !rx_s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg   <= R_IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (rx_state_reg)
        R_IDLE: begin
          baud_cnt_reg <= '0;
          if (!rx_s_reg) rx_state_reg <= R_START;
        end
        R_START: begin
          if (half_done) begin
            // Re-check mid start bit; a high here was a glitch.
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            rx_state_reg <= rx_s_reg ? R_IDLE : R_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        R_DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rx_s_reg, shift_reg[7:1]};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) rx_state_reg <= R_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        R_STOP: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (rx_s_reg) begin
              byte_data_reg  <= shift_reg;
              byte_valid_reg <= 1'b1;
              rx_state_reg   <= R_IDLE;
            end else begin
              frame_err_reg  <= 1'b1;
              rx_state_reg   <= R_BREAK;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
          end
        end
        R_BREAK: begin
          // Hold off until the line returns high so a long break is not
          // mistaken for a stream of start bits.
          if (rx_s_reg) rx_state_reg <= R_IDLE;
        end
        default: rx_state_reg <= R_IDLE;
      endcase
    end
  end

  // ---------------- Packet parser FSM ----------------
  parse_state_t     p_state_reg;
  logic [7:0]       cmd_reg;
  logic [7:0]       addr_reg;
  logic [7:0]       data_reg;
  logic [CNT_W-1:0] tout_cnt_reg;
  logic             take_pic_reg;
  logic             hdr_en_reg;
  logic [7:0]       conf_addr_reg;
  logic [7:0]       conf_data_reg;
  logic             sccb_start_reg;
  logic             cmd_err_reg;

  logic in_packet;
  logic tout_hit;

  assign in_packet = (p_state_reg != P_SYNC);
  assign tout_hit  = in_packet && !byte_valid_reg &&
                     (tout_cnt_reg == CNT_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_reg    <= P_SYNC;
      cmd_reg        <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      tout_cnt_reg   <= '0;
      take_pic_reg   <= 1'b0;
      hdr_en_reg     <= 1'b0;
      conf_addr_reg  <= '0;
      conf_data_reg  <= '0;
      sccb_start_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      take_pic_reg   <= 1'b0;
      sccb_start_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;

      if (!in_packet || byte_valid_reg) tout_cnt_reg <= '0;
      else                              tout_cnt_reg <= tout_cnt_reg + CNT_W'(1);

      if (in_packet && frame_evt) begin
        p_state_reg <= P_SYNC;
        cmd_err_reg <= 1'b1;
      end else if (tout_hit) begin
        p_state_reg <= P_SYNC;
        cmd_err_reg <= 1'b1;
      end else if (byte_valid_reg) begin
        case (p_state_reg)
          P_SYNC: if (byte_data_reg == 8'hA5) p_state_reg <= P_CMD;
          P_CMD: begin
            cmd_reg     <= byte_data_reg;
            p_state_reg <= P_ADDR;
          end
          P_ADDR: begin
            addr_reg    <= byte_data_reg;
            p_state_reg <= P_DATA;
          end
          P_DATA: begin
            data_reg    <= byte_data_reg;
            p_state_reg <= P_CHK;
          end
          P_CHK: begin
            p_state_reg <= P_SYNC;
            if (byte_data_reg == (cmd_reg ^ addr_reg ^ data_reg)) begin
              // Single case on CMD keeps take_pic and sccb_start exclusive.
              case (cmd_reg)
                8'h01: take_pic_reg <= 1'b1;
                8'h02: hdr_en_reg   <= data_reg[0];
                8'h03: begin
                  conf_addr_reg  <= addr_reg;
                  conf_data_reg  <= data_reg;
                  sccb_start_reg <= 1'b1;
                end
                default: cmd_err_reg <= 1'b1;
              endcase
            end else begin
              cmd_err_reg <= 1'b1;
            end
          end
          default: p_state_reg <= P_SYNC;
        endcase
      end
    end
  end

  assign cmd_if.byte_data  = byte_data_reg;
  assign cmd_if.byte_valid = byte_valid_reg;
  assign cmd_if.frame_err  = frame_err_reg;
  assign cmd_if.take_pic   = take_pic_reg;
  assign cmd_if.hdr_en     = hdr_en_reg;
  assign cmd_if.conf_addr  = conf_addr_reg;
  assign cmd_if.conf_data  = conf_data_reg;
  assign cmd_if.sccb_start = sccb_start_reg;
  assign cmd_if.cmd_err    = cmd_err_reg;
  assign cmd_if.busy_led   = in_packet;

endmodule

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed plus randomized packets for uart_cmd_rx, compared against a
// packet-level model of the command rules (checksum, command table, holding
// registers). Fast baud (16 clocks per bit) and a 20 bit-time timeout.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;
  localparam int CPB  = 16;
  localparam int TOUT = 320;
  localparam int GAP  = 8;

  logic clk;
  logic rst_n;
  logic RX;

  uart_cmd_rx_if cmd_if ();

  uart_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .cmd_if (cmd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors: count high cycles of each strobe, sampled on negedge.
  int cyc = 0;
  int bv_cnt = 0, fe_cnt = 0, tp_cnt = 0, sc_cnt = 0, ce_cnt = 0;
  int fe_ce_cnt = 0, both_cnt = 0;
  int last_bv_cyc = 0, last_act_cyc = 0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    bv_cnt    <= bv_cnt + int'(cmd_if.byte_valid === 1'b1);
    fe_cnt    <= fe_cnt + int'(cmd_if.frame_err === 1'b1);
    tp_cnt    <= tp_cnt + int'(cmd_if.take_pic === 1'b1);
    sc_cnt    <= sc_cnt + int'(cmd_if.sccb_start === 1'b1);
    ce_cnt    <= ce_cnt + int'(cmd_if.cmd_err === 1'b1);
    fe_ce_cnt <= fe_ce_cnt + int'(cmd_if.frame_err === 1'b1 && cmd_if.cmd_err === 1'b1);
    both_cnt  <= both_cnt + int'(cmd_if.take_pic === 1'b1 && cmd_if.sccb_start === 1'b1);
    if (cmd_if.byte_valid === 1'b1) last_bv_cyc <= cyc;
    if (cmd_if.take_pic === 1'b1 || cmd_if.sccb_start === 1'b1 || cmd_if.cmd_err === 1'b1)
      last_act_cyc <= cyc;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the decoder's held outputs.
  logic       model_hdr;
  logic [7:0] model_addr;
  logic [7:0] model_data;
  logic [7:0] model_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_data"},  32'(cmd_if.byte_data), 32'h0);
    chk({tag, "_byte_valid"}, 32'(cmd_if.byte_valid), 32'h0);
    chk({tag, "_frame_err"},  32'(cmd_if.frame_err), 32'h0);
    chk({tag, "_take_pic"},   32'(cmd_if.take_pic), 32'h0);
    chk({tag, "_hdr_en"},     32'(cmd_if.hdr_en), 32'h0);
    chk({tag, "_conf_addr"},  32'(cmd_if.conf_addr), 32'h0);
    chk({tag, "_conf_data"},  32'(cmd_if.conf_data), 32'h0);
    chk({tag, "_sccb_start"}, 32'(cmd_if.sccb_start), 32'h0);
    chk({tag, "_cmd_err"},    32'(cmd_if.cmd_err), 32'h0);
    chk({tag, "_busy_led"},   32'(cmd_if.busy_led), 32'h0);
  endtask

  // Sends one full packet and checks every effect against the rule-level model.
  task automatic run_packet(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] cs);
    int  bv0, fe0, tp0, sc0, ce0;
    bit  good, exp_tp, exp_sc, exp_ce;
    bv0 = bv_cnt; fe0 = fe_cnt; tp0 = tp_cnt; sc0 = sc_cnt; ce0 = ce_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(cmd, 1'b1);
    send_byte(addr, 1'b1);
    send_byte(data, 1'b1);
    send_byte(cs, 1'b1);
    repeat (2) @(negedge clk);
    good   = (cs == (cmd ^ addr ^ data));
    exp_tp = good && cmd == 8'h01;
    exp_sc = good && cmd == 8'h03;
    exp_ce = !good || cmd == 8'h00 || cmd > 8'h03;
    if (good && cmd == 8'h02) model_hdr = data[0];
    if (exp_sc) begin
      model_addr = addr;
      model_data = data;
    end
    model_byte = cs;
    $display("packet %s: A5 %02h %02h %02h %02h take_pic=%0d sccb=%0d cmd_err=%0d hdr_en=%0b",
             tag, cmd, addr, data, cs, tp_cnt - tp0, sc_cnt - sc0, ce_cnt - ce0, cmd_if.hdr_en);
    chk({tag, "_take_pic"},   32'(tp_cnt - tp0), 32'(exp_tp));
    chk({tag, "_sccb_start"}, 32'(sc_cnt - sc0), 32'(exp_sc));
    chk({tag, "_cmd_err"},    32'(ce_cnt - ce0), 32'(exp_ce));
    chk({tag, "_frame_err"},  32'(fe_cnt - fe0), 32'h0);
    chk({tag, "_byte_valid"}, 32'(bv_cnt - bv0), 32'd5);
    chk({tag, "_byte_data"},  32'(cmd_if.byte_data), 32'(model_byte));
    chk({tag, "_hdr_en"},     32'(cmd_if.hdr_en), 32'(model_hdr));
    chk({tag, "_conf_addr"},  32'(cmd_if.conf_addr), 32'(model_addr));
    chk({tag, "_conf_data"},  32'(cmd_if.conf_data), 32'(model_data));
    chk({tag, "_busy_led"},   32'(cmd_if.busy_led), 32'h0);
    if (exp_tp || exp_sc || exp_ce)
      chk({tag, "_latency"}, 32'(last_act_cyc - last_bv_cyc), 32'd1);
  endtask

  initial begin
    int bv0, fe0, tp0, ce0, fece0;
    logic [7:0] c, a, d, s, j;

    RX = 1'b1;
    rst_n = 1'b0;
    model_hdr = 1'b0; model_addr = 8'h00; model_data = 8'h00; model_byte = 8'h00;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain byte
    bv0 = bv_cnt; fe0 = fe_cnt; ce0 = ce_cnt;
    send_byte(8'h5A, 1'b1);
    $display("byte 5A: byte_data=%02h byte_valid pulses=%0d", cmd_if.byte_data, bv_cnt - bv0);
    chk("byte5a_data",  32'(cmd_if.byte_data), 32'h5A);
    chk("byte5a_valid", 32'(bv_cnt - bv0), 32'd1);
    chk("byte5a_ferr",  32'(fe_cnt - fe0), 32'd0);
    chk("byte5a_cerr",  32'(ce_cnt - ce0), 32'd0);
    chk("byte5a_busy",  32'(cmd_if.busy_led), 32'd0);

    // Directed commands
    run_packet("take_pic", 8'h01, 8'h00, 8'h00, 8'h01);
    run_packet("hdr_on",   8'h02, 8'h00, 8'h01, 8'h03);
    run_packet("hdr_off",  8'h02, 8'h00, 8'h00, 8'h02);
    run_packet("conf",     8'h03, 8'h12, 8'h80, 8'h91);
    run_packet("conf_bad", 8'h03, 8'h12, 8'h80, 8'h00);
    run_packet("bad_cmd",  8'h07, 8'h10, 8'h20, 8'h37);

    // Framing error in the middle of a packet
    bv0 = bv_cnt; fe0 = fe_cnt; ce0 = ce_cnt; fece0 = fe_ce_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    $display("frame error mid-packet: frame_err=%0d cmd_err=%0d together=%0d busy=%0b",
             fe_cnt - fe0, ce_cnt - ce0, fe_ce_cnt - fece0, cmd_if.busy_led);
    chk("ferr_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("ferr_cmd_err",   32'(ce_cnt - ce0), 32'd1);
    chk("ferr_same_cyc",  32'(fe_ce_cnt - fece0), 32'd1);
    chk("ferr_bv",        32'(bv_cnt - bv0), 32'd2);
    chk("ferr_byte_data", 32'(cmd_if.byte_data), 32'h01);
    chk("ferr_busy",      32'(cmd_if.busy_led), 32'd0);
    run_packet("after_ferr", 8'h01, 8'h00, 8'h00, 8'h01);

    // Inter-byte timeout
    ce0 = ce_cnt; tp0 = tp_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("tout_busy_before", 32'(cmd_if.busy_led), 32'd1);
    repeat (TOUT + 50) @(negedge clk);
    $display("timeout: cmd_err=%0d busy=%0b", ce_cnt - ce0, cmd_if.busy_led);
    chk("tout_cmd_err",  32'(ce_cnt - ce0), 32'd1);
    chk("tout_busy",     32'(cmd_if.busy_led), 32'd0);
    chk("tout_take_pic", 32'(tp_cnt - tp0), 32'd0);

    // Short glitch on the line
    bv0 = bv_cnt; fe0 = fe_cnt;
    @(negedge clk);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    $display("glitch: byte_valid=%0d frame_err=%0d", bv_cnt - bv0, fe_cnt - fe0);
    chk("glitch_bv",  32'(bv_cnt - bv0), 32'd0);
    chk("glitch_fe",  32'(fe_cnt - fe0), 32'd0);
    chk("glitch_bsy", 32'(cmd_if.busy_led), 32'd0);

    // Randomized packets, optionally preceded by a junk byte
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        ce0 = ce_cnt;
        send_byte(j, 1'b1);
        model_byte = j;
        $display("junk byte %02h: cmd_err=%0d", j, ce_cnt - ce0);
        chk("junk_cmd_err", 32'(ce_cnt - ce0), 32'd0);
        chk("junk_data",    32'(cmd_if.byte_data), 32'(j));
        chk("junk_busy",    32'(cmd_if.busy_led), 32'd0);
      end
      case ($urandom_range(0, 4))
        0:       c = 8'h01;
        1:       c = 8'h02;
        2:       c = 8'h03;
        3:       c = 8'($urandom_range(0, 255));
        default: c = 8'h00;
      endcase
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      s = c ^ a ^ d;
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      run_packet("rand", c, a, d, s);
    end

    // Reset in the middle of a packet and a byte
    run_packet("pre_rst_hdr",  8'h02, 8'h00, 8'h01, 8'h03);
    run_packet("pre_rst_conf", 8'h03, 8'h5C, 8'h3B, 8'h5C ^ 8'h3B ^ 8'h03);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    @(negedge clk);
    RX = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("reset mid-packet: hdr_en=%0b conf_addr=%02h busy=%0b",
             cmd_if.hdr_en, cmd_if.conf_addr, cmd_if.busy_led);
    check_all_zero("midrst");
    RX = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    model_hdr = 1'b0; model_addr = 8'h00; model_data = 8'h00; model_byte = 8'h00;
    repeat (20) @(negedge clk);
    run_packet("post_rst", 8'h01, 8'h00, 8'h00, 8'h01);

    chk("exclusive_pulses", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
